if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 24 ++
 rtl/if_stage.sv | 121 ++++++++++++
 tb/tb_if_stage.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect, and decode handshake.
// master = fetch stage, slave = memory / decode / branch-unit side.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    modport master (
        output imem_req, imem_addr, id_valid, id_inst, id_pc, id_pc4,
        input  imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_inst, id_pc, id_pc4,
        output imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/if_stage.sv
// Generic synchronous FIFO with flush; head entry visible combinationally.
// Latency: one cycle from push to head visibility.
// Backpressure: caller must not push when full unless popping in the same cycle.
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic [CW-1:0]    o_cnt
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) r_wptr <= nxt(r_wptr);
            if (i_pop)  r_rptr <= nxt(r_rptr);
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wptr] <= i_push_dat;
    end

    assign o_head_dat = r_mem[r_rptr];
    assign o_cnt      = r_cnt;
endmodule

// Instruction fetch: issues word fetches, buffers returns in a 2-entry FIFO, flushes on redirect.
// Latency: first instruction reaches decode two cycles after its fetch is issued.
// Backpressure: stops issuing once buffered + in-flight words reach 2; nothing is ever dropped.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    if_stage_if.master     bus
);
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_t;

    logic [31:0] r_pc;
    logic [31:0] r_inflight_pc;
    logic        r_inflight;

    logic [1:0]  w_cnt;
    logic [1:0]  w_occ;
    logic        w_req;
    logic        w_pop;
    logic        w_valid;
    fetch_t      w_head;
    fetch_t      w_push_dat;

    assign w_valid    = (w_cnt != 2'd0) && !bus.redirect_valid;
    assign w_pop      = w_valid && bus.id_ready;
    assign w_occ      = w_cnt + {1'b0, r_inflight};
    // A pop frees a slot this cycle, so issuing keeps the 1-per-cycle stream going.
    assign w_req      = !bus.redirect_valid && ((w_occ < 2'd2) || w_pop);
    assign w_push_dat = '{inst: bus.imem_rdata, pc: r_inflight_pc};

    fifo #(.WIDTH($bits(fetch_t)), .DEPTH(2)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (bus.redirect_valid),
        .i_push     (r_inflight),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_cnt      (w_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req) r_inflight_pc <= r_pc;
            if (bus.redirect_valid) r_pc <= bus.redirect_pc & ~32'h3;
            else if (w_req)         r_pc <= r_pc + 32'd4;
        end
    end

    // Internal state is frozen during reset; only the visible request needs masking.
    assign bus.imem_req  = w_req && rst_n;
    assign bus.imem_addr = r_pc;
    assign bus.id_valid  = w_valid;
    assign bus.id_inst   = w_head.inst;
    assign bus.id_pc     = w_head.pc;
    assign bus.id_pc4    = w_head.pc + 32'd4;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: scoreboard of expected decode PCs checked by a negedge monitor,
// plus directed cycle checks of fetch requests, stalls, redirects, reset and PC wrap.
module tb_if_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    if_stage_if bus1();
    if_stage_if bus2();

    if_stage u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // Memory returns the bitwise inverse of the address, one cycle after the request.
    always @(posedge clk) begin
        if (bus1.imem_req) bus1.imem_rdata <= ~bus1.imem_addr;
        if (bus2.imem_req) bus2.imem_rdata <= ~bus2.imem_addr;
    end

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (rst_n === 1'b1 && bus1.id_valid === 1'b1 && bus1.id_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_transfer: got id_pc %h, expected no transfer", bus1.id_pc);
            end else begin
                e = exp_q.pop_front();
                chk("id_pc",   bus1.id_pc,   e);
                chk("id_inst", bus1.id_inst, ~e);
                chk("id_pc4",  bus1.id_pc4,  e + 32'd4);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs until every expected word is delivered, then drops id_ready; checks cycle count.
    task automatic drain(input string name, input int exp_n);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL %s_timeout: got %0d words undelivered, expected 0", name, exp_q.size());
            exp_q.delete();
        end else begin
            chk(name, n, exp_n);
        end
        bus1.id_ready = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        rst_n               = 1'b0;
        bus1.id_ready       = 1'b0;
        bus1.redirect_valid = 1'b0;
        bus1.redirect_pc    = '0;
        bus2.id_ready       = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        step();
        step();
        chk("rst_imem_req",  bus1.imem_req, 1'b0);
        chk("rst_id_valid",  bus1.id_valid, 1'b0);
        chk("rst_imem_req2", bus2.imem_req, 1'b0);

        // Streaming from reset with decode always ready.
        bus1.id_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        rst_n = 1'b1;
        #1;
        chk("c0_imem_req",  bus1.imem_req,  1'b1);
        chk("c0_imem_addr", bus1.imem_addr, 32'h0);
        chk("c0_id_valid",  bus1.id_valid,  1'b0);
        step();
        chk("c1_imem_addr", bus1.imem_addr, 32'h4);
        chk("c1_id_valid",  bus1.id_valid,  1'b0);
        step();
        chk("c2_id_valid",  bus1.id_valid,  1'b1);
        drain("throughput_cycles", 8);

        // Decode stalled from reset: exactly two words buffered, fetch stops.
        reset_pulse();
        step();
        step();
        chk("stall_first_valid", bus1.id_valid, 1'b1);
        repeat (6) step();
        chk("stall_imem_req", bus1.imem_req, 1'b0);
        chk("stall_id_valid", bus1.id_valid, 1'b1);
        chk("stall_id_pc",    bus1.id_pc,    32'h0);
        chk("stall_id_inst",  bus1.id_inst,  32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        bus1.id_ready = 1'b1;
        drain("stall_release_cycles", 4);

        // Reset mid-stream with the FIFO full.
        repeat (4) step();
        chk("full_id_valid", bus1.id_valid, 1'b1);
        chk("full_imem_req", bus1.imem_req, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_imem_req", bus1.imem_req, 1'b0);
        chk("midrst_id_valid", bus1.id_valid, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        chk("restart_imem_req",  bus1.imem_req,  1'b1);
        chk("restart_imem_addr", bus1.imem_addr, 32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        bus1.id_ready = 1'b1;
        repeat (4) step();

        // Redirect with one word buffered and one in flight; misaligned target.
        chk("pre_redirect_pending", exp_q.size(), 0);
        bus1.redirect_valid = 1'b1;
        bus1.redirect_pc    = 32'h0000_0103;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        #1;
        chk("redir_id_valid", bus1.id_valid, 1'b0);
        chk("redir_imem_req", bus1.imem_req, 1'b0);
        step();
        bus1.redirect_valid = 1'b0;
        #1;
        chk("redir_r1_imem_req",  bus1.imem_req,  1'b1);
        chk("redir_r1_imem_addr", bus1.imem_addr, 32'h100);
        chk("redir_r1_id_valid",  bus1.id_valid,  1'b0);
        step();
        chk("redir_r2_imem_addr", bus1.imem_addr, 32'h104);
        chk("redir_r2_id_valid",  bus1.id_valid,  1'b0);
        step();
        chk("redir_r3_id_valid",  bus1.id_valid,  1'b1);
        drain("redirect_stream_cycles", 3);

        // Back-to-back redirects with the FIFO full: the later target wins.
        repeat (3) step();
        chk("full2_id_valid", bus1.id_valid, 1'b1);
        chk("full2_imem_req", bus1.imem_req, 1'b0);
        bus1.redirect_valid = 1'b1;
        bus1.redirect_pc    = 32'h200;
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h304);
        #1;
        chk("dbl_a_id_valid", bus1.id_valid, 1'b0);
        step();
        bus1.redirect_pc = 32'h300;
        #1;
        chk("dbl_b_imem_req", bus1.imem_req, 1'b0);
        chk("dbl_b_id_valid", bus1.id_valid, 1'b0);
        step();
        bus1.redirect_valid = 1'b0;
        bus1.id_ready       = 1'b1;
        #1;
        chk("dbl_c_imem_req",  bus1.imem_req,  1'b1);
        chk("dbl_c_imem_addr", bus1.imem_addr, 32'h300);
        step();
        chk("dbl_d_imem_addr", bus1.imem_addr, 32'h304);
        chk("dbl_d_id_valid",  bus1.id_valid,  1'b0);
        drain("double_redirect_cycles", 3);

        // Address wrap on the instance reset to 0xFFFF_FFF8.
        reset_pulse();
        chk("wrap_c0_imem_req",  bus2.imem_req,  1'b1);
        chk("wrap_c0_imem_addr", bus2.imem_addr, 32'hFFFF_FFF8);
        step();
        chk("wrap_c1_imem_addr", bus2.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_c2_imem_addr", bus2.imem_addr, 32'h0000_0000);
        chk("wrap_c2_id_pc",     bus2.id_pc,     32'hFFFF_FFF8);
        chk("wrap_c2_id_pc4",    bus2.id_pc4,    32'hFFFF_FFFC);
        chk("wrap_c2_id_inst",   bus2.id_inst,   32'h0000_0007);
        step();
        chk("wrap_c3_id_pc",     bus2.id_pc,     32'hFFFF_FFFC);
        chk("wrap_c3_id_pc4",    bus2.id_pc4,    32'h0000_0000);
        chk("wrap_c3_id_inst",   bus2.id_inst,   32'h0000_0003);
        step();
        chk("wrap_c4_id_pc",     bus2.id_pc,     32'h0000_0000);
        chk("wrap_c4_id_pc4",    bus2.id_pc4,    32'h0000_0004);

        step();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
